// File: rtl/pwm_pkg.sv
// Shared types and the duty clamp for the PWM output stage.
package pwm_pkg;

  localparam int DUTY_W = 16;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } pwm_state_t;

  typedef struct packed {
    logic [DUTY_W-1:0] duty;
    logic              sat;
  } clamp_t;

  // Limit to [min_v, max_v] first, then to the physically possible 0..period.
  // The sat flag records whether either step changed the value, even if the
  // second step happens to land back on the original request.
  function automatic clamp_t clamp_duty(
    input logic signed [DUTY_W-1:0] val,
    input logic signed [DUTY_W-1:0] min_v,
    input logic signed [DUTY_W-1:0] max_v,
    input logic        [DUTY_W-1:0] period
  );
    logic signed [DUTY_W:0] v, lo, hi, p, t;
    logic                   s;
    clamp_t                 r;
    v  = {val[DUTY_W-1], val};
    lo = {min_v[DUTY_W-1], min_v};
    hi = {max_v[DUTY_W-1], max_v};
    p  = {1'b0, period};
    s  = 1'b0;
    if (v < lo) begin
      t = lo;
      s = 1'b1;
    end else if (v > hi) begin
      t = hi;
      s = 1'b1;
    end else begin
      t = v;
    end
    if (t < 17'sd0) begin
      t = 17'sd0;
      s = 1'b1;
    end else if (t > p) begin
      t = p;
      s = 1'b1;
    end
    r.duty = t[DUTY_W-1:0];
    r.sat  = s;
    return r;
  endfunction

endpackage

// File: rtl/pwm_slew_step.sv
// One slew-limited step of a duty value toward its target; step 0 jumps directly.
module pwm_slew_step
  import pwm_pkg::*;
(
  input  logic [DUTY_W-1:0] cur,
  input  logic [DUTY_W-1:0] target,
  input  logic [DUTY_W-1:0] step,
  output logic [DUTY_W-1:0] duty_next
);

  // Move at most one step toward the target; both operands are unsigned duties.
  always_comb begin
    duty_next = target;
    if (step != '0) begin
      if (target > cur) begin
        if ((target - cur) > step) duty_next = cur + step;
      end else begin
        if ((cur - target) > step) duty_next = cur - step;
      end
    end
  end

endmodule

// File: rtl/pwm_out_gen.sv
// PWM waveform generator: samples the requested duty once per period,
// clamps and slew-limits it, and stops only at a period boundary.
//
// state | meaning
// OFF   | idle, counter held at 0, output low
// RUN   | counting, duty sampled at each boundary
// STOP  | en dropped, finishing the current period before OFF
module pwm_out_gen
  import pwm_pkg::*;
#(
  parameter int PERIOD    = 1000,
  parameter int SLEW_STEP = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DUTY_W-1:0] pwm_val,
  input  logic signed [DUTY_W-1:0] pwm_min,
  input  logic signed [DUTY_W-1:0] pwm_max,
  output logic                     pwm_o,
  output logic                     period_start,
  output logic        [DUTY_W-1:0] duty_applied,
  output logic                     sat
);

  localparam logic [DUTY_W-1:0] PERIOD_C = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] LAST_C   = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] STEP_C   = DUTY_W'(SLEW_STEP);

  pwm_state_t        state;
  logic [DUTY_W-1:0] cnt;
  logic              last;
  clamp_t            clamp_res;
  logic [DUTY_W-1:0] duty_next;

  // Clamp the live request; it is only committed at a RUN boundary.
  always_comb begin
    last      = (cnt == LAST_C);
    clamp_res = clamp_duty(pwm_val, pwm_min, pwm_max, PERIOD_C);
  end

  pwm_slew_step u_slew (
    .cur       (duty_applied),
    .target    (clamp_res.duty),
    .step      (STEP_C),
    .duty_next (duty_next)
  );

  // Sequencer, period counter, duty/sat update and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= OFF;
      cnt          <= '0;
      duty_applied <= '0;
      sat          <= 1'b0;
      pwm_o        <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_o        <= (state != OFF) && (cnt < duty_applied);
      period_start <= (state != OFF) && (cnt == '0);
      case (state)
        OFF: begin
          cnt <= '0;
          if (en) state <= RUN;
        end
        RUN: begin
          cnt <= last ? '0 : cnt + 16'd1;
          if (last) begin
            duty_applied <= duty_next;
            sat          <= clamp_res.sat;
          end
          if (!en) state <= STOP;
        end
        STOP: begin
          cnt <= last ? '0 : cnt + 16'd1;
          if (en) begin
            state <= RUN;
          end else if (last) begin
            state        <= OFF;
            duty_applied <= '0;
          end
        end
        default: begin
          state <= OFF;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_out_gen.sv
// Directed bench for pwm_out_gen with PERIOD=100; one instance without slew,
// one with SLEW_STEP=8, both driven by the same stimulus.
module tb_pwm_out_gen;

  logic               clk = 1'b0;
  logic               rst, en;
  logic signed [15:0] pwm_val, pwm_min, pwm_max;
  logic               pwm_o0, ps0, sat0;
  logic        [15:0] duty0;
  logic               pwm_o8, ps8, sat8;
  logic        [15:0] duty8;

  int n_chk  = 0;
  int n_fail = 0;

  // mid-period stimulus events, index within period (-1 = none)
  int                 ev_val_i, ev_val2_i, ev_enlo_i, ev_enhi_i;
  logic signed [15:0] ev_val_v, ev_val2_v;

  int h, p, f;

  always #5 clk = ~clk;

  pwm_out_gen #(.PERIOD(100), .SLEW_STEP(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .pwm_val(pwm_val), .pwm_min(pwm_min),
    .pwm_max(pwm_max), .pwm_o(pwm_o0), .period_start(ps0),
    .duty_applied(duty0), .sat(sat0)
  );

  pwm_out_gen #(.PERIOD(100), .SLEW_STEP(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .pwm_val(pwm_val), .pwm_min(pwm_min),
    .pwm_max(pwm_max), .pwm_o(pwm_o8), .period_start(ps8),
    .duty_applied(duty8), .sat(sat8)
  );

  task automatic chk(input string tag, input int obs, input int want);
    n_chk++;
    if (obs != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic clear_ev();
    ev_val_i  = -1;
    ev_val2_i = -1;
    ev_enlo_i = -1;
    ev_enhi_i = -1;
    ev_val_v  = 16'sd0;
    ev_val2_v = 16'sd0;
  endtask

  // Advance (at negedges) until period_start is seen, bounded.
  task automatic wait_ps(input string tag);
    int k;
    k = 0;
    while (!ps0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!ps0) chk({tag, "_ps_timeout"}, 0, 1);
  endtask

  // Observe 100 samples starting at the current one; ends on the next period's first sample.
  task automatic run_period(output int highs, output int pscnt, output int first_low);
    highs     = 0;
    pscnt     = 0;
    first_low = 100;
    for (int i = 0; i < 100; i++) begin
      if (pwm_o0) highs++;
      else if (first_low == 100) first_low = i;
      if (ps0) pscnt++;
      if (i == ev_val_i)  pwm_val = ev_val_v;
      if (i == ev_val2_i) pwm_val = ev_val2_v;
      if (i == ev_enlo_i) en = 1'b0;
      if (i == ev_enhi_i) en = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    pwm_val = 16'sd0; pwm_min = 16'sd0; pwm_max = 16'sd100;
    clear_ev();
    repeat (3) @(negedge clk);
    chk("rst_pwm",  pwm_o0, 0);
    chk("rst_ps",   ps0,    0);
    chk("rst_duty", duty0,  0);
    chk("rst_sat",  sat0,   0);
    chk("rst_pwm8", pwm_o8, 0);
    chk("rst_ps8",  ps8,    0);
    chk("rst_sat8", sat8,   0);
    chk("rst_duty8", duty8, 0);

    // soft start then duty 30; slew instance ramps 8,16,24,30
    en = 1'b1; pwm_val = 16'sd30;
    rst = 1'b0;
    @(negedge clk);
    chk("ps_not_yet", ps0, 0);
    wait_ps("start");
    run_period(h, p, f);
    chk("soft_hi", h, 0);
    chk("soft_ps", p, 1);
    chk("b_duty", duty0, 30);
    chk("b_sat",  sat0,  0);
    chk("slew_1", duty8, 8);
    run_period(h, p, f);
    chk("b_hi", h, 30);
    chk("b_first_low", f, 30);
    chk("b_ps", p, 1);
    chk("slew_2", duty8, 16);
    run_period(h, p, f);
    chk("c_hi", h, 30);
    chk("slew_3", duty8, 24);
    run_period(h, p, f);
    chk("slew_4", duty8, 30);

    // over max -> clamp to PERIOD, constant high
    pwm_val = 16'sd150;
    run_period(h, p, f);
    chk("max_duty", duty0, 100);
    chk("max_sat",  sat0,  1);
    pwm_val = -16'sd5; pwm_min = -16'sd10;
    run_period(h, p, f);
    chk("max_hi", h, 100);
    chk("max_ps", p, 1);

    // negative -> clamp to 0, constant low
    chk("neg_duty", duty0, 0);
    chk("neg_sat",  sat0,  1);
    pwm_val = 16'sd50; pwm_min = 16'sd0;
    run_period(h, p, f);
    chk("neg_hi", h, 0);

    // duty 50 with mid-period val glitch and a 5-cycle en dropout
    chk("d50_duty", duty0, 50);
    chk("d50_sat",  sat0,  0);
    ev_val_i = 39; ev_val_v = 16'sd70;
    ev_val2_i = 59; ev_val2_v = 16'sd50;
    ev_enlo_i = 20; ev_enhi_i = 25;
    run_period(h, p, f);
    chk("pulse_hi", h, 50);
    chk("pulse_first_low", f, 50);
    chk("pulse_ps", p, 1);
    chk("glitch_ignored", duty0, 50);

    // en drops at cnt=10: period completes, then OFF
    clear_ev();
    ev_enlo_i = 9;
    run_period(h, p, f);
    chk("stop_hi", h, 50);
    chk("stop_ps", p, 1);
    clear_ev();
    run_period(h, p, f);
    chk("off_hi", h, 0);
    chk("off_ps", p, 0);
    chk("off_duty", duty0, 0);

    // restart, raise duty to 50, reset mid-period while high
    en = 1'b1; pwm_val = 16'sd30;
    @(negedge clk);
    wait_ps("restart");
    run_period(h, p, f);
    chk("re_soft_hi", h, 0);
    chk("re_duty", duty0, 30);
    pwm_val = 16'sd50;
    run_period(h, p, f);
    chk("re_hi", h, 30);
    chk("m_duty", duty0, 50);
    repeat (19) @(negedge clk);
    chk("pre_rst_hi", pwm_o0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_pwm",  pwm_o0, 0);
    chk("mid_rst_duty", duty0,  0);
    chk("mid_rst_ps",   ps0,    0);
    chk("mid_rst_sat",  sat0,   0);
    pwm_val = 16'sd30;
    rst = 1'b0;
    @(negedge clk);
    wait_ps("after_rst");
    run_period(h, p, f);
    chk("ar_soft_hi", h, 0);
    run_period(h, p, f);
    chk("ar_hi", h, 30);
    chk("ar_first_low", f, 30);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
